// File: rtl/main_pipe_req_arb.sv
// N-way request arbiter feeding a single registered output stage.
// Fixed-priority or round-robin selection, with a per-channel starvation override.
module main_pipe_req_arb #(
  parameter int N_IN       = 4,
  parameter int DATA_W     = 128,
  parameter int STARVE_MAX = 15
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      io_rr_mode,
  input  logic [N_IN-1:0]           io_in_valid,
  output logic [N_IN-1:0]           io_in_ready,
  input  logic [N_IN*DATA_W-1:0]    io_in_bits,
  output logic                      io_out_valid,
  input  logic                      io_out_ready,
  output logic [DATA_W-1:0]         io_out_bits,
  output logic [$clog2(N_IN)-1:0]   io_out_chosen
);

  localparam int IDX_W = $clog2(N_IN);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [IDX_W-1:0]  rr_ptr;
  logic [CNT_W-1:0]  wait_cnt [N_IN];

  logic              load_en;
  logic              starve_hit, low_hit, hi_hit;
  logic [IDX_W-1:0]  starve_idx, low_idx, hi_idx;
  logic              grant_vld;
  logic [IDX_W-1:0]  grant_idx;
  logic [DATA_W-1:0] sel_bits;

  assign load_en = !io_out_valid || io_out_ready;

  // Round-robin order from rr_ptr+1 equals: lowest valid above rr_ptr,
  // otherwise lowest valid overall (everything valid is then at or below rr_ptr).
  always_comb begin
    starve_hit = 1'b0;
    starve_idx = '0;
    low_hit    = 1'b0;
    low_idx    = '0;
    hi_hit     = 1'b0;
    hi_idx     = '0;
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (io_in_valid[i] && (wait_cnt[i] == CNT_MAX)) begin
        starve_hit = 1'b1;
        starve_idx = IDX_W'(i);
      end
      if (io_in_valid[i]) begin
        low_hit = 1'b1;
        low_idx = IDX_W'(i);
      end
      if (io_in_valid[i] && (IDX_W'(i) > rr_ptr)) begin
        hi_hit = 1'b1;
        hi_idx = IDX_W'(i);
      end
    end
    grant_vld = low_hit;
    if (starve_hit)
      grant_idx = starve_idx;
    else if (io_rr_mode && hi_hit)
      grant_idx = hi_idx;
    else
      grant_idx = low_idx;
  end

  always_comb begin
    sel_bits    = '0;
    io_in_ready = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_bits       = io_in_bits[i*DATA_W +: DATA_W];
        io_in_ready[i] = reset && load_en && grant_vld;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_out_valid  <= 1'b0;
      io_out_bits   <= '0;
      io_out_chosen <= '0;
      rr_ptr        <= IDX_W'(N_IN - 1);
    end else if (load_en) begin
      io_out_valid <= grant_vld;
      if (grant_vld) begin
        io_out_bits   <= sel_bits;
        io_out_chosen <= grant_idx;
        rr_ptr        <= grant_idx;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_IN; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (!io_in_valid[i] || io_in_ready[i])
          wait_cnt[i] <= '0;
        else if (wait_cnt[i] != CNT_MAX)
          wait_cnt[i] <= wait_cnt[i] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_main_pipe_req_arb.sv
// Directed bench for main_pipe_req_arb: scoreboard of expected transfers,
// popped by a negedge monitor whenever the output stage hands data downstream.
module tb_main_pipe_req_arb;

  localparam int N_IN = 4;
  localparam int DW   = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              io_rr_mode = 1'b0;
  logic [N_IN-1:0]   io_in_valid = '0;
  logic [N_IN-1:0]   io_in_ready;
  logic [N_IN*DW-1:0] io_in_bits;
  logic              io_out_valid;
  logic              io_out_ready = 1'b0;
  logic [DW-1:0]     io_out_bits;
  logic [1:0]        io_out_chosen;
  logic [7:0]        tag = 8'h01;

  typedef struct packed {
    logic [1:0]    ch;
    logic [DW-1:0] bits;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  main_pipe_req_arb #(.N_IN(N_IN), .DATA_W(DW), .STARVE_MAX(3)) dut (
    .clock         (clock),
    .reset         (reset),
    .io_rr_mode    (io_rr_mode),
    .io_in_valid   (io_in_valid),
    .io_in_ready   (io_in_ready),
    .io_in_bits    (io_in_bits),
    .io_out_valid  (io_out_valid),
    .io_out_ready  (io_out_ready),
    .io_out_bits   (io_out_bits),
    .io_out_chosen (io_out_chosen)
  );

  always #5 clock = ~clock;

  // Channel i carries {C, i, tag}
  assign io_in_bits = {4'hC, 4'h3, tag, 4'hC, 4'h2, tag, 4'hC, 4'h1, tag, 4'hC, 4'h0, tag};

  function automatic logic [DW-1:0] mk(input int i);
    return {4'hC, 4'(i), tag};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic ordy, input logic [3:0] exp_rdy,
                       input logic [1:0] exp_ch, input bit push);
    io_in_valid  = v;
    io_out_ready = ordy;
    #1;
    chk("in_ready", io_in_ready, exp_rdy);
    if (push && exp_rdy != 4'b0000) sb.push_back({exp_ch, mk(exp_ch)});
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    io_in_valid  = 4'hF;
    io_out_ready = 1'b1;
    #1;
    chk("rst_out_valid", io_out_valid, 0);
    chk("rst_in_ready", io_in_ready, 0);
    repeat (2) @(posedge clock);
    #1;
    chk("rst_chosen", io_out_chosen, 0);
    chk("rst_bits", io_out_bits, 0);
    reset       = 1'b1;
    io_in_valid = '0;
  endtask

  always @(negedge clock) begin
    if (reset && io_out_valid && io_out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL out_unexpected: chosen %0d bits %0h with empty scoreboard", io_out_chosen, io_out_bits);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_chosen", io_out_chosen, e.ch);
        chk("out_bits", io_out_bits, e.bits);
      end
    end
  end

  initial begin
    @(posedge clock);
    #1;

    // Fixed priority: 1 before 3, 3 once 1 drops
    do_reset();
    io_rr_mode = 1'b0;
    drive(4'b1010, 1, 4'b0010, 1, 1); step();
    drive(4'b1000, 1, 4'b1000, 3, 1); step();
    drive(4'b0000, 1, 4'b0000, 0, 1); step();
    step();

    // Round robin, all valid
    do_reset();
    io_rr_mode = 1'b1;
    drive(4'b1111, 1, 4'b0001, 0, 1); step();
    drive(4'b1111, 1, 4'b0010, 1, 1); step();
    drive(4'b1111, 1, 4'b0100, 2, 1); step();
    drive(4'b1111, 1, 4'b1000, 3, 1); step();
    drive(4'b1111, 1, 4'b0001, 0, 1); step();
    drive(4'b0000, 1, 4'b0000, 0, 1); step();
    step();

    // Backpressure: held output stays put while inputs change
    do_reset();
    io_rr_mode = 1'b0;
    tag = 8'h01;
    drive(4'b0100, 1, 4'b0100, 2, 1); step();
    tag = 8'h02;
    repeat (5) begin
      drive(4'b0011, 0, 4'b0000, 0, 0);
      chk("hold_valid", io_out_valid, 1);
      chk("hold_chosen", io_out_chosen, 2);
      chk("hold_bits", io_out_bits, 16'hC201);
      step();
    end
    drive(4'b0011, 1, 4'b0001, 0, 1); step();
    drive(4'b0000, 1, 4'b0000, 0, 0); step();
    step();

    // Starvation override in fixed mode
    do_reset();
    io_rr_mode = 1'b0;
    tag = 8'h03;
    repeat (3) begin
      drive(4'b0101, 1, 4'b0001, 0, 1); step();
    end
    drive(4'b0101, 1, 4'b0100, 2, 1); step();
    repeat (2) begin
      drive(4'b0101, 1, 4'b0001, 0, 1); step();
    end
    drive(4'b0000, 1, 4'b0000, 0, 0); step();
    step();

    // Async reset mid-transfer, RR restarts at 0
    do_reset();
    io_rr_mode = 1'b1;
    tag = 8'h04;
    drive(4'b0010, 0, 4'b0010, 1, 0); step();
    chk("pre_rst_valid", io_out_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_valid", io_out_valid, 0);
    chk("async_rst_ready", io_in_ready, 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    chk("no_replay_valid", io_out_valid, 0);
    drive(4'b1111, 1, 4'b0001, 0, 1); step();
    drive(4'b1111, 1, 4'b0010, 1, 1); step();
    drive(4'b0000, 1, 4'b0000, 0, 0); step();
    step();
    step();

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/main_pipe_req_arb.md
MAIN_PIPE_REQ_ARB -- requirements
Module: main_pipe_req_arb

Interface
REQ-001 SHALL have parameter N_IN, default 4, number of request channels (2..16).
REQ-002 SHALL have parameter DATA_W, default 128, payload width per channel.
REQ-003 SHALL have parameter STARVE_MAX, default 15, number of wait cycles after which a channel is promoted (1..255).
REQ-004 SHALL have `clock`  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have `reset`  input  1  asynchronous, active-low reset.
REQ-006 SHALL have `io_rr_mode`  input  1  0 = fixed priority (index 0 highest); 1 = round-robin.
REQ-007 SHALL have `io_in_valid`  input  N_IN  per-channel request valid.
REQ-008 SHALL have `io_in_ready`  output  N_IN  per-channel accept.
REQ-009 SHALL have `io_in_bits`  input  N_IN*DATA_W  payloads; channel i at bits [i*DATA_W +: DATA_W].
REQ-010 SHALL have `io_out_valid`  output  1  registered output valid.
REQ-011 SHALL have `io_out_ready`  input  1  downstream accept.
REQ-012 SHALL have `io_out_bits`  output  DATA_W  registered winning payload.
REQ-013 SHALL have `io_out_chosen`  output  clog2(N_IN)  index of the channel that supplied io_out_bits.

Function
REQ-014 SHALL contain one output register stage (valid, bits, chosen); request-to-output latency exactly 1 cycle.
REQ-015 Stage SHALL accept (load enable) when !io_out_valid || io_out_ready; full throughput of one transfer per cycle under continuous io_out_ready.
REQ-016 io_in_ready[i] SHALL be high iff load enable && channel i is the grant; at most one bit of io_in_ready high per cycle; io_in_ready SHALL NOT depend on io_in_valid[i] of the same channel except through grant selection.
REQ-017 Grant SHALL only be given to a channel with io_in_valid high; with no valid channel, no grant, and on load enable io_out_valid becomes 0.
REQ-018 Held output (io_out_valid && !io_out_ready) SHALL keep io_out_bits and io_out_chosen stable until accepted.
REQ-019 Fixed-priority mode SHALL grant the lowest-index valid channel.
REQ-020 Round-robin mode SHALL grant the first valid channel searching upward from rr_ptr+1, wrapping N_IN-1 -> 0; rr_ptr SHALL update to the granted index on each transfer into the stage, in either mode.
REQ-021 Each channel SHALL have a saturating wait counter: increments when io_in_valid[i] && !io_in_ready[i], clears when io_in_ready[i] or !io_in_valid[i], saturates at STARVE_MAX.
REQ-022 Any channel with wait counter == STARVE_MAX SHALL be starved; if any starved channel is valid, the grant SHALL go to the lowest-index starved channel, overriding both modes.
REQ-023 io_rr_mode change SHALL take effect on the next grant decision; no state flush.
REQ-024 Counter and pointer arithmetic SHALL be unsigned, width clog2 of range; no overflow wrap of wait counters.

Reset
REQ-025 On reset assertion, asynchronously: io_out_valid=0, io_out_bits=0, io_out_chosen=0, rr_ptr=N_IN-1 (so first RR grant starts at 0), all wait counters=0.
REQ-026 Reset asserted mid-transfer SHALL drop the held output; no replay after deassertion.
REQ-027 io_in_ready SHALL be 0 while reset asserted.

Verification
REQ-028 Fixed mode, N_IN=4, valid=4'b1010, out_ready=1 -> cycle 1 ready=4'b0010, out_chosen=1 next cycle; then channel 3 granted once channel 1 drops.
REQ-029 RR mode, all 4 channels valid continuously, out_ready=1 -> out_chosen sequence 0,1,2,3,0 on consecutive cycles.
REQ-030 Backpressure: out_valid=1, out_ready=0 for 5 cycles -> io_in_ready=0 throughout, io_out_bits/chosen unchanged; out_ready=1 -> transfer plus new load same cycle.
REQ-031 Starvation, fixed mode, STARVE_MAX=3: channels 0 and 2 valid continuously -> channel 2 granted on 4th cycle of waiting, then channel 0 resumes.
REQ-032 Reset asserted asynchronously between clock edges with out_valid=1 -> out_valid=0 immediately; after release, RR grant starts at channel 0.
